// File: rtl/nv_nvdla_pdp_pool1d_lanes_pkg.sv
// Shared definitions for the PDP horizontal pooling engine: combine modes,
// sequencer states and the accumulator width rule.
package pdp_pool_pkg;

  typedef enum logic [1:0] {
    MODE_MAX  = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_SUM  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD_L,
    ST_DATA,
    ST_PAD_R,
    ST_FLUSH
  } state_e;

  // Wide enough to sum KMAX full-scale signed inputs without overflow.
  function automatic int acc_width(input int data_w, input int kmax);
    return data_w + $clog2(kmax);
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_pool1d_lanes_if.sv
// Element input stream and pooled-result output stream of the 1D pooling engine.
interface nv_nvdla_pdp_pool1d_lanes_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 19
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*DATA_W-1:0]  in_pd;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*ACC_W-1:0]   out_pd;
  logic                     out_last;

  modport master (
    output in_valid, in_pd, out_ready,
    input  in_ready, out_valid, out_pd, out_last
  );

  modport slave (
    input  in_valid, in_pd, out_ready,
    output in_ready, out_valid, out_pd, out_last
  );
endinterface

// File: rtl/nv_nvdla_pdp_pool1d_lanes_lane_acc.sv
// One lane of window accumulators: KMAX slots, each opened, combined and
// closed under control of the shared position sequencer.
module nv_nvdla_pdp_pool_lane_acc
  import pdp_pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KMAX   = 8,
  parameter int ACC_W  = acc_width(16, 8),
  parameter int SW     = $clog2(KMAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_i,
  input  logic                     open_i,
  input  logic [SW-1:0]            open_slot_i,
  input  logic [SW-1:0]            close_slot_i,
  input  mode_e                    mode_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [ACC_W-1:0]  close_val_o
);

  function automatic logic signed [ACC_W-1:0] combine(
    input mode_e                   m,
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    case (m)
      MODE_MAX: combine = (a > b) ? a : b;
      MODE_MIN: combine = (a < b) ? a : b;
      default:  combine = a + b;
    endcase
  endfunction

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] acc_q [KMAX];
  logic signed [ACC_W-1:0] acc_d [KMAX];

  assign x_ext = {{(ACC_W-DATA_W){x_i[DATA_W-1]}}, x_i};

  always_comb begin
    for (int i = 0; i < KMAX; i++) begin
      acc_d[i] = acc_q[i];
      if (adv_i) begin
        if (open_i && (open_slot_i == SW'(i))) acc_d[i] = x_ext;
        else                                   acc_d[i] = combine(mode_i, acc_q[i], x_ext);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KMAX; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < KMAX; i++) acc_q[i] <= acc_d[i];
    end
  end

  // A window that opens and closes on the same position sees only this element.
  assign close_val_o = (open_i && (open_slot_i == close_slot_i)) ? x_ext
                     : combine(mode_i, acc_q[close_slot_i], x_ext);

endmodule

// File: rtl/nv_nvdla_pdp_pool1d_lanes.sv
// Horizontal pooling engine: pads each line, walks positions, opens/closes
// overlapping windows and emits one LANES-wide pooled result per window.
module nv_nvdla_pdp_pool1d_lanes
  import pdp_pool_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int KMAX   = 8,
  parameter int CNT_W  = 13
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        op_en,
  input  logic [CNT_W-1:0]            cfg_width,
  input  logic [CNT_W-1:0]            cfg_lines,
  input  logic [$clog2(KMAX):0]       cfg_kernel,
  input  logic [$clog2(KMAX):0]       cfg_stride,
  input  logic [$clog2(KMAX)-1:0]     cfg_pad_left,
  input  logic [$clog2(KMAX)-1:0]     cfg_pad_right,
  input  logic signed [DATA_W-1:0]    cfg_pad_value,
  input  logic [1:0]                  cfg_mode,
  nv_nvdla_pdp_pool1d_lanes_if.slave  pool_if,
  output logic                        done
);

  localparam int ACC_W = acc_width(DATA_W, KMAX);
  localparam int KW    = $clog2(KMAX) + 1;
  localparam int PADW  = $clog2(KMAX);
  localparam int SW    = $clog2(KMAX);
  localparam int PW    = CNT_W + 1;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    slot_inc = (s == SW'(KMAX - 1)) ? '0 : s + SW'(1);
  endfunction

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         width_q, lines_q, line_q, line_d, cnt_q, cnt_d;
  logic [KW-1:0]            kernel_q, stride_q, start_kernel;
  logic [PADW-1:0]          padl_q, padr_q;
  logic signed [DATA_W-1:0] padv_q;
  mode_e                    mode_q;
  logic [PW-1:0]            pos_q, nopen_q, nclose_q, last_pos;
  logic [SW-1:0]            oslot_q, cslot_q;
  logic                     out_valid_q, out_last_q, done_q, done_d;
  logic [LANES*ACC_W-1:0]   out_pd_q, close_pd;
  logic                     stall, adv, do_open, do_close, close_last;
  logic                     line_start, line_end;

  assign stall    = out_valid_q & ~pool_if.out_ready;
  assign adv      = ~stall & ((state_q == ST_PAD_L) | (state_q == ST_PAD_R) |
                              ((state_q == ST_DATA) & pool_if.in_valid));
  assign last_pos = PW'(padl_q) + PW'(width_q) + PW'(padr_q);
  // Windows open and close strictly in order, so one pair of trackers suffices.
  assign do_open    = adv & (pos_q == nopen_q) & ((nopen_q + PW'(kernel_q) - PW'(1)) <= last_pos);
  assign do_close   = adv & (pos_q == nclose_q) & (nclose_q <= last_pos);
  assign close_last = (nclose_q + PW'(stride_q)) > last_pos;
  assign start_kernel = (state_q == ST_IDLE) ? cfg_kernel : kernel_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    line_start = 1'b0;
    line_end   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (op_en) begin
        line_d     = '0;
        line_start = 1'b1;
        if (cfg_pad_left != '0) begin
          state_d = ST_PAD_L;
          cnt_d   = CNT_W'(cfg_pad_left) - CNT_W'(1);
        end else begin
          state_d = ST_DATA;
          cnt_d   = cfg_width;
        end
      end
      ST_PAD_L: if (adv) begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = width_q;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DATA: if (adv) begin
        if (cnt_q == '0) begin
          if (padr_q != '0) begin
            state_d = ST_PAD_R;
            cnt_d   = CNT_W'(padr_q) - CNT_W'(1);
          end else line_end = 1'b1;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_PAD_R: if (adv) begin
        if (cnt_q == '0) line_end = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_FLUSH: if (!out_valid_q) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (line_end) begin
      if (line_q == lines_q) state_d = ST_FLUSH;
      else begin
        line_d     = line_q + CNT_W'(1);
        line_start = 1'b1;
        if (padl_q != '0) begin
          state_d = ST_PAD_L;
          cnt_d   = CNT_W'(padl_q) - CNT_W'(1);
        end else begin
          state_d = ST_DATA;
          cnt_d   = width_q;
        end
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      done_q   <= 1'b0;
      width_q  <= '0;
      lines_q  <= '0;
      kernel_q <= '0;
      stride_q <= '0;
      padl_q   <= '0;
      padr_q   <= '0;
      padv_q   <= '0;
      mode_q   <= MODE_MAX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      done_q  <= done_d;
      if ((state_q == ST_IDLE) && op_en) begin
        width_q  <= cfg_width;
        lines_q  <= cfg_lines;
        kernel_q <= cfg_kernel;
        stride_q <= cfg_stride;
        padl_q   <= cfg_pad_left;
        padr_q   <= cfg_pad_right;
        padv_q   <= cfg_pad_value;
        mode_q   <= mode_e'(cfg_mode);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      pos_q    <= '0;
      nopen_q  <= '0;
      nclose_q <= '0;
      oslot_q  <= '0;
      cslot_q  <= '0;
    end else if (line_start) begin
      pos_q    <= '0;
      nopen_q  <= '0;
      nclose_q <= PW'(start_kernel) - PW'(1);
      oslot_q  <= '0;
      cslot_q  <= '0;
    end else if (adv) begin
      pos_q <= pos_q + PW'(1);
      if (do_open) begin
        nopen_q <= nopen_q + PW'(stride_q);
        oslot_q <= slot_inc(oslot_q);
      end
      if (do_close) begin
        nclose_q <= nclose_q + PW'(stride_q);
        cslot_q  <= slot_inc(cslot_q);
      end
    end
  end

  // Output register: loads on a closing position, drains on out_ready.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_valid_q <= 1'b0;
      out_pd_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (do_close) begin
      out_valid_q <= 1'b1;
      out_pd_q    <= close_pd;
      out_last_q  <= close_last;
    end else if (pool_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] x;
    logic signed [ACC_W-1:0]  cv;
    assign x = (state_q == ST_DATA) ? pool_if.in_pd[g*DATA_W +: DATA_W] : padv_q;
    nv_nvdla_pdp_pool_lane_acc #(
      .DATA_W (DATA_W),
      .KMAX   (KMAX),
      .ACC_W  (ACC_W),
      .SW     (SW)
    ) u_acc (
      .clk          (nvdla_core_clk),
      .rst          (nvdla_core_rst),
      .adv_i        (adv),
      .open_i       (do_open),
      .open_slot_i  (oslot_q),
      .close_slot_i (cslot_q),
      .mode_i       (mode_q),
      .x_i          (x),
      .close_val_o  (cv)
    );
    assign close_pd[g*ACC_W +: ACC_W] = cv;
  end

  assign pool_if.in_ready  = (state_q == ST_DATA) & ~stall;
  assign pool_if.out_valid = out_valid_q;
  assign pool_if.out_pd    = out_pd_q;
  assign pool_if.out_last  = out_last_q;
  assign done              = done_q;

endmodule
